narrow_to_wide_fifo: RTL and testbench
======================================

NARROW_TO_WIDE_FIFO -- requirements
Module: narrow_to_wide_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, meaning log2 of the number of wide-word slots.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the narrow (write) word width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  input  1  write request.
REQ-006 SHALL have port w_data  input  DATA_WIDTH  narrow write data.
REQ-007 SHALL have port rd  input  1  read request.
REQ-008 SHALL have port r_data  output  2*DATA_WIDTH  wide read data, first-word fall-through.
REQ-009 SHALL have port full  output  1  no narrow slot free.
REQ-010 SHALL have port empty  output  1  no complete wide word available.

Function
REQ-011 SHALL store 2^(ADDR_WIDTH+1) narrow entries and present them as 2^ADDR_WIDTH wide words.
REQ-012 SHALL accept a write iff wr & ~full, storing w_data at the write pointer and advancing it by one narrow entry.
REQ-013 SHALL accept a read iff rd & ~empty, advancing the read pointer by one wide word (two narrow entries).
REQ-014 SHALL evaluate both acceptances from the pre-edge flags, so when wr and rd are both high, each is accepted or rejected independently.
REQ-015 SHALL place the earlier-written narrow entry of a pair in r_data[DATA_WIDTH-1:0] and the later entry in the upper half.
REQ-016 SHALL drive r_data combinationally from the wide word at the read pointer when empty=0, and drive all zeros when empty=1.
REQ-017 SHALL keep a narrow-entry occupancy count; next value = count + write_accepted - 2*read_accepted.
REQ-018 SHALL assert full when count = 2^(ADDR_WIDTH+1), and assert empty when count < 2.
REQ-019 SHALL update flags on the same edge as the accepted operation, visible in the following cycle.
REQ-020 SHALL wrap both pointers modulo storage size with no gap or lost entry.
REQ-021 SHALL hold one odd entry (count = 1) with empty=1 until its partner is written.
REQ-022 SHALL ignore rejected requests entirely: no pointer, count, or storage change and no error output.

Reset
REQ-023 SHALL, while reset=0, force pointers and count to 0, empty=1, full=0, r_data=0, independent of clk.
REQ-024 SHALL discard all stored data, including any odd entry, on reset mid-operation; storage contents need not be cleared.

Configuration
REQ-025 SHALL, when macro NARROW_TO_WIDE_FIFO_LEVEL_EN is defined, add output port level (ADDR_WIDTH+2 bits) equal to the registered narrow-entry count, resetting to 0.
REQ-026 SHALL, when NARROW_TO_WIDE_FIFO_LEVEL_EN is undefined, omit the level port with all other behaviour identical.

Structure
REQ-027 SHALL place default width constants and the occupancy-count type width function in package narrow_to_wide_fifo_pkg.
REQ-028 SHALL implement pointer, count and flag logic in sub-module n2w_fifo_ctrl, with storage and the read mux in the top level.

Verification (ADDR_WIDTH=3, DATA_WIDTH=8)
REQ-029 SHALL check reset: assert reset=0 mid-stream -> immediately empty=1, full=0, r_data=16'h0000, level=0.
REQ-030 SHALL check pairing: write 8'h11 then 8'h22 -> empty=0 the cycle after the second write, r_data=16'h2211.
REQ-031 SHALL check the odd entry: write 8'hAA only, pulse rd -> empty stays 1 and the read is ignored; write 8'hBB -> r_data=16'hBBAA.
REQ-032 SHALL check full and overflow: write 8'h00..8'h0F -> full=1; write 8'hFF is ignored; eight reads return 16'h0100, 16'h0302, ... 16'h0F0E, then empty=1.
REQ-033 SHALL check simultaneous operations at full: wr=1, rd=1 -> read accepted, write rejected, level=14, full=0.
REQ-034 SHALL check wrap-around: stream 40 bytes with reads interleaved so no overflow occurs -> 20 wide words in order, with no loss or duplication.

Source files
------------

// File: rtl/narrow_to_wide_fifo_pkg.sv
// Shared defaults and width helpers for the narrow-to-wide FIFO.
package narrow_to_wide_fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Count must represent 0 .. 2^(addr_width+1) inclusive.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/n2w_fifo_ctrl.sv
// Pointer, occupancy count and flag logic for narrow_to_wide_fifo.
// Optional level output enabled by macro NARROW_TO_WIDE_FIFO_LEVEL_EN.
module n2w_fifo_ctrl
  import narrow_to_wide_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  full,
  output logic                  empty
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
  ,
  output logic [count_width(ADDR_WIDTH)-1:0] level
`endif
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]         CAPACITY = CW'(2 ** (ADDR_WIDTH + 1));
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_TWO  = CW'(2);
  localparam logic [ADDR_WIDTH:0]   WSTEP    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] RSTEP    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  rd_en;

  always_comb begin
    // Both acceptances use the registered flags, so wr and rd never interact.
    wr_en   = wr & ~full_q;
    rd_en   = rd & ~empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_en) wptr_d = wptr_q + WSTEP;
    if (rd_en) rptr_d = rptr_q + RSTEP;
    count_d = count_q + (wr_en ? CNT_ONE : '0) - (rd_en ? CNT_TWO : '0);
    full_d  = (count_d == CAPACITY);
    empty_d = (count_d < CNT_TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign waddr = wptr_q;
  assign raddr = rptr_q;
  assign full  = full_q;
  assign empty = empty_q;
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: rtl/narrow_to_wide_fifo.sv
// FIFO written one narrow word at a time and read as first-word fall-through
// wide pairs. Macro NARROW_TO_WIDE_FIFO_LEVEL_EN adds the level output.
module narrow_to_wide_fifo
  import narrow_to_wide_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    full,
  output logic                    empty
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
  ,
  output logic [count_width(ADDR_WIDTH)-1:0] level
`endif
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  n2w_fifo_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .wr_en (wr_en),
    .waddr (waddr),
    .raddr (raddr),
    .full  (full),
    .empty (empty)
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  // Storage is left unreset; the cleared pointers and count make old data unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= w_data;
  end

  always_comb begin
    r_data = '0;
    if (!empty) r_data = {mem_q[{raddr, 1'b1}], mem_q[{raddr, 1'b0}]};
  end

endmodule

// File: tb/tb_narrow_to_wide_fifo.sv
// Directed self-checking bench for narrow_to_wide_fifo (ADDR_WIDTH=3, DATA_WIDTH=8).
module tb_narrow_to_wide_fifo;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [7:0]  w_data;
  logic        rd;
  logic [15:0] r_data;
  logic        full;
  logic        empty;
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
  logic [4:0]  level;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  narrow_to_wide_fifo #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .full   (full),
    .empty  (empty)
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr = 1'b0;
    rd = 1'b0;
    w_data = '0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [7:0] d);
    wr = 1'b1;
    w_data = d;
    step();
    wr = 1'b0;
  endtask

  task automatic do_read();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    do_write(8'h5A);
    do_write(8'h6B);
    do_write(8'h7C);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fails++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++;
    if (r_data !== 16'h0000) begin n_fails++; $display("FAIL reset_rdata: got %h want 0000", r_data); end
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 5'd0) begin n_fails++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
    #2;
    reset = 1'b1;
    step();
    do_write(8'h31);
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_odd_discarded: empty got %b want 1", empty); end
    do_write(8'h42);
    n_checks++;
    if (r_data !== 16'h4231) begin n_fails++; $display("FAIL reset_ptr_cleared: got %h want 4231", r_data); end
  endtask

  task automatic test_pairing();
    apply_reset();
    do_write(8'h11);
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL pair_empty_after_one: got %b want 1", empty); end
    do_write(8'h22);
    n_checks++;
    if (empty !== 1'b0) begin n_fails++; $display("FAIL pair_empty_after_two: got %b want 0", empty); end
    n_checks++;
    if (r_data !== 16'h2211) begin n_fails++; $display("FAIL pair_rdata: got %h want 2211", r_data); end
    do_read();
    n_checks++;
    if (empty !== 1'b1 || r_data !== 16'h0000) begin
      n_fails++; $display("FAIL pair_after_read: empty %b rdata %h want 1 0000", empty, r_data);
    end
  endtask

  task automatic test_odd_entry();
    apply_reset();
    do_write(8'hAA);
    do_read();
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL odd_empty: got %b want 1", empty); end
    n_checks++;
    if (r_data !== 16'h0000) begin n_fails++; $display("FAIL odd_rdata_zero: got %h want 0000", r_data); end
    do_write(8'hBB);
    n_checks++;
    if (r_data !== 16'hBBAA) begin n_fails++; $display("FAIL odd_pair: got %h want BBAA", r_data); end
  endtask

  task automatic test_full_overflow();
    logic [15:0] exp;
    apply_reset();
    for (int i = 0; i < 15; i++) do_write(8'(i));
    n_checks++;
    if (full !== 1'b0) begin n_fails++; $display("FAIL full_at_15: got %b want 0", full); end
    do_write(8'h0F);
    n_checks++;
    if (full !== 1'b1) begin n_fails++; $display("FAIL full_at_16: got %b want 1", full); end
    do_write(8'hFF);
    n_checks++;
    if (full !== 1'b1) begin n_fails++; $display("FAIL full_after_overflow: got %b want 1", full); end
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 5'd16) begin n_fails++; $display("FAIL level_full: got %0d want 16", level); end
`endif
    for (int i = 0; i < 8; i++) begin
      exp = {8'(2 * i + 1), 8'(2 * i)};
      n_checks++;
      if (empty !== 1'b0 || r_data !== exp) begin
        n_fails++; $display("FAIL drain_word%0d: got %h empty %b want %h", i, r_data, empty, exp);
      end
      do_read();
    end
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fails++; $display("FAIL drain_end_flags: empty %b full %b want 1 0", empty, full);
    end
  endtask

  task automatic test_simul_full();
    logic [15:0] exp;
    apply_reset();
    for (int i = 0; i < 16; i++) do_write(8'(i));
    wr = 1'b1;
    rd = 1'b1;
    w_data = 8'hEE;
    step();
    wr = 1'b0;
    rd = 1'b0;
    n_checks++;
    if (full !== 1'b0) begin n_fails++; $display("FAIL simul_full_flag: got %b want 0", full); end
    n_checks++;
    if (r_data !== 16'h0302) begin n_fails++; $display("FAIL simul_head: got %h want 0302", r_data); end
`ifdef NARROW_TO_WIDE_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 5'd14) begin n_fails++; $display("FAIL simul_level: got %0d want 14", level); end
`endif
    for (int i = 1; i < 8; i++) begin
      exp = {8'(2 * i + 1), 8'(2 * i)};
      n_checks++;
      if (r_data !== exp) begin n_fails++; $display("FAIL simul_drain%0d: got %h want %h", i, r_data, exp); end
      do_read();
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL simul_no_extra: empty got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0]  q[$];
    logic [15:0] exp;
    int          mcount;
    int          nwords;
    apply_reset();
    mcount = 0;
    nwords = 0;
    for (int k = 0; k < 40; k++) begin
      wr = 1'b1;
      w_data = 8'(8'h40 + k);
      rd = (mcount >= 6);
      if (rd) begin
        exp = {q[1], q[0]};
        n_checks++;
        if (empty !== 1'b0 || r_data !== exp) begin
          n_fails++; $display("FAIL wrap_word%0d: got %h empty %b want %h", nwords, r_data, empty, exp);
        end
        void'(q.pop_front());
        void'(q.pop_front());
        nwords++;
        mcount -= 2;
      end
      q.push_back(w_data);
      mcount++;
      step();
    end
    wr = 1'b0;
    rd = 1'b0;
    for (int j = 0; j < 20 && q.size() >= 2; j++) begin
      exp = {q[1], q[0]};
      n_checks++;
      if (empty !== 1'b0 || r_data !== exp) begin
        n_fails++; $display("FAIL wrap_drain%0d: got %h empty %b want %h", nwords, r_data, empty, exp);
      end
      void'(q.pop_front());
      void'(q.pop_front());
      nwords++;
      do_read();
    end
    n_checks++;
    if (nwords !== 20) begin n_fails++; $display("FAIL wrap_count: got %0d want 20", nwords); end
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL wrap_end_empty: got %b want 1", empty); end
  endtask

  initial begin
    reset = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    w_data = '0;
    #12;
    test_reset();
    test_pairing();
    test_odd_entry();
    test_full_overflow();
    test_simul_full();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
